// File: rtl/keypad_scan_debounce_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : keypad_scan_debounce_if
// Description : Keypad matrix lines and debounced key outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_debounce_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_pulse;

    // master: keypad / consumer side; slave: the scanner itself
    modport master (
        output row,
        input  col,
        input  key_value,
        input  key_valid,
        input  key_pulse
    );

    modport slave (
        input  row,
        output col,
        output key_value,
        output key_valid,
        output key_pulse
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : keypad_scan_debounce
// Description : 4x4 keypad column scanner with press/release debouncing.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    keypad_scan_debounce_if.slave kp
);

    localparam int c_PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_DONE  = c_CNT_W'(DEBOUNCE_TICKS);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_row_meta;
    logic [3:0]           r_row_s;
    logic [c_PRESC_W-1:0] r_presc;
    logic [3:0]           r_col;
    logic [1:0]           r_row_idx;
    logic [1:0]           r_col_idx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_key_value;
    logic                 r_key_valid;
    logic                 r_key_pulse;

    logic [3:0]           w_col_nxt;
    logic [1:0]           w_row_idx_nxt;
    logic [1:0]           w_col_idx_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [3:0]           w_key_value_nxt;
    logic                 w_key_valid_nxt;
    logic                 w_key_pulse_nxt;

    logic                 w_tick;
    logic [3:0]           w_col_rot;
    logic [1:0]           w_row_first;
    logic [1:0]           w_col_enc;
    logic                 w_key_row;
    logic [c_CNT_W-1:0]   w_cnt_inc;

    assign w_tick    = (r_presc == c_PRESC_MAX);
    assign w_col_rot = {r_col[2:0], r_col[3]};
    assign w_key_row = r_row_s[r_row_idx];
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // Lowest active row wins when several keys share the driven column
    always_comb begin
        w_row_first = 2'd3;
        if (r_row_s[0])      w_row_first = 2'd0;
        else if (r_row_s[1]) w_row_first = 2'd1;
        else if (r_row_s[2]) w_row_first = 2'd2;
    end

    always_comb begin
        case (r_col)
            4'b0010: w_col_enc = 2'd1;
            4'b0100: w_col_enc = 2'd2;
            4'b1000: w_col_enc = 2'd3;
            default: w_col_enc = 2'd0;
        endcase
    end

    // Synchronizer and free-running prescaler
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_meta <= 4'b0000;
            r_row_s    <= 4'b0000;
            r_presc    <= '0;
        end else begin
            r_row_meta <= kp.row;
            r_row_s    <= r_row_meta;
            r_presc    <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SCAN;
            r_col       <= 4'b0001;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_cnt       <= '0;
            r_key_value <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_value <= w_key_value_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_pulse <= w_key_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_row_idx_nxt   = r_row_idx;
        w_col_idx_nxt   = r_col_idx;
        w_cnt_nxt       = r_cnt;
        w_key_value_nxt = r_key_value;
        w_key_valid_nxt = r_key_valid;
        w_key_pulse_nxt = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (r_row_s == 4'b0000) begin
                        w_col_nxt = w_col_rot;
                    end else begin
                        w_row_idx_nxt = w_row_first;
                        w_col_idx_nxt = w_col_enc;
                        w_cnt_nxt     = c_CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt     = ST_HELD;
                            w_key_value_nxt = {w_row_first, w_col_enc};
                            w_key_valid_nxt = 1'b1;
                            w_key_pulse_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_DEB_PRESS;
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_key_row) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_DONE) begin
                            w_state_nxt     = ST_HELD;
                            w_key_value_nxt = {r_row_idx, r_col_idx};
                            w_key_valid_nxt = 1'b1;
                            w_key_pulse_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_SCAN;
                        w_col_nxt   = w_col_rot;
                    end
                end
                ST_HELD: begin
                    if (!w_key_row) begin
                        w_cnt_nxt = c_CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt     = ST_SCAN;
                            w_key_valid_nxt = 1'b0;
                            w_col_nxt       = w_col_rot;
                        end else begin
                            w_state_nxt = ST_DEB_REL;
                        end
                    end
                end
                ST_DEB_REL: begin
                    if (!w_key_row) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_DONE) begin
                            w_state_nxt     = ST_SCAN;
                            w_key_valid_nxt = 1'b0;
                            w_col_nxt       = w_col_rot;
                        end
                    end else begin
                        // release bounce: back to held without a new pulse
                        w_state_nxt = ST_HELD;
                    end
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    assign kp.col       = r_col;
    assign kp.key_value = r_key_value;
    assign kp.key_valid = r_key_valid;
    assign kp.key_pulse = r_key_pulse;

endmodule
`default_nettype wire
